// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, drives the instruction-memory word
// address and registers the returned instruction into the IF/ID register.
// Branch redirect inserts one bubble; a misaligned redirect target raises a
// sticky fault that only reset clears.
// Optional build macro IFU_PERF_CNT_EN adds fetch_count / stall_count ports.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] A,
    input  logic [31:0] RD,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    output logic        fault
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    localparam int DATA_W = 32;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   pc_p0, pc_p0_d;
    logic [DATA_W-1:0]   pc_p1_d, instr_p1_d;
    logic                vld_p1_d, fault_d;

    // Memory address is the PC itself; RD comes back in the same cycle.
    assign A = pc_p0;

    // Next-state and next-register values; everything holds unless overridden.
    always_comb begin
        state_d    = state_q;
        pc_p0_d    = pc_p0;
        pc_p1_d    = pc_out;
        instr_p1_d = instr_out;
        vld_p1_d   = instr_valid;
        fault_d    = fault;
        case (state_q)
            RUN: begin
                if (branch_taken) begin
                    vld_p1_d = 1'b0;
                    if (branch_target[1:0] != 2'b00) begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                    end else begin
                        pc_p0_d = branch_target;
                    end
                end else if (!stall) begin
                    instr_p1_d = RD;
                    pc_p1_d    = pc_p0;
                    vld_p1_d   = 1'b1;
                    pc_p0_d    = pc_p0 + PC_INC;
                end
            end
            FAULT: begin
                vld_p1_d = 1'b0;
            end
        endcase
    end

    // ---- stage 0 -> stage 1 boundary: PC and IF/ID register update ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            pc_p0       <= RESET_PC;
            pc_out      <= '0;
            instr_out   <= '0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_p0       <= pc_p0_d;
            pc_out      <= pc_p1_d;
            instr_out   <= instr_p1_d;
            instr_valid <= vld_p1_d;
            fault       <= fault_d;
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic fetch_en, stall_en;
    assign fetch_en = (state_q == RUN) && !branch_taken && !stall;
    assign stall_en = (state_q == RUN) && !branch_taken && stall;

    // Performance counters; free-running and wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (fetch_en) fetch_count <= fetch_count + 32'd1;
            if (stall_en) stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed plan steps followed by
// randomized traffic, compared against a rule-level reference model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, stall, branch_taken;
    logic [31:0] branch_target, A, RD, pc_out, instr_out;
    logic        instr_valid, fault;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_count, stall_count;
`endif

    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .A(A), .RD(RD), .pc_out(pc_out), .instr_out(instr_out),
        .instr_valid(instr_valid), .fault(fault)
`ifdef IFU_PERF_CNT_EN
        , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory: three preloaded words, hashed contents elsewhere.
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a[31:2])
            30'd0:   mem_rd = 32'h00502223;
            30'd1:   mem_rd = 32'h00602423;
            30'd2:   mem_rd = 32'h00702623;
            default: mem_rd = (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
        endcase
    endfunction
    assign RD = mem_rd(A);

    int npass = 0;
    int ntotal = 0;

    // Reference model state
    logic [31:0] m_pc, m_pc_out, m_instr, m_fcnt, m_scnt;
    logic        m_vld, m_fault, m_dead;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // One clock edge: drive inputs, advance the model by the fetch rules,
    // then compare every output against the model.
    task automatic step(input logic r, input logic s, input logic b, input logic [31:0] t);
        reset = r; stall = s; branch_taken = b; branch_target = t;
        @(posedge clk);
        if (r) begin
            m_pc = 32'h0; m_pc_out = 0; m_instr = 0; m_vld = 0;
            m_fault = 0; m_dead = 0; m_fcnt = 0; m_scnt = 0;
        end else if (m_dead) begin
            m_vld = 0;
        end else if (b) begin
            m_vld = 0;
            if (t % 4 != 0) begin
                m_fault = 1; m_dead = 1;
            end else begin
                m_pc = t;
            end
        end else if (s) begin
            m_scnt = m_scnt + 1;
        end else begin
            m_instr = mem_rd(m_pc);
            m_pc_out = m_pc;
            m_vld = 1;
            m_pc = m_pc + 4;
            m_fcnt = m_fcnt + 1;
        end
        #1;
        chk("A", A, m_pc);
        chk("pc_out", pc_out, m_pc_out);
        chk("instr_out", instr_out, m_instr);
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_vld});
        chk("fault", {31'b0, fault}, {31'b0, m_fault});
`ifdef IFU_PERF_CNT_EN
        chk("fetch_count", fetch_count, m_fcnt);
        chk("stall_count", stall_count, m_scnt);
`endif
    endtask

    initial begin
        logic s, b, r;
        logic [31:0] t;
        int  k;

        // Reset state
        step(1, 0, 0, 0);
        step(1, 1, 1, 32'h40);
        chk("rst_A", A, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_fault", {31'b0, fault}, 32'd0);

        // Plan 1: three sequential fetches
        step(0, 0, 0, 0);
        chk("p1_pc0", pc_out, 32'h0);
        chk("p1_in0", instr_out, 32'h00502223);
        chk("p1_v0", {31'b0, instr_valid}, 32'd1);
        step(0, 0, 0, 0);
        chk("p1_in1", instr_out, 32'h00602423);
        step(0, 0, 0, 0);
        chk("p1_pc2", pc_out, 32'h8);
        chk("p1_in2", instr_out, 32'h00702623);
        chk("p1_A", A, 32'hC);

        // Plan 2: stall after first fetch
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("p2_pc", pc_out, 32'h0);
        chk("p2_in", instr_out, 32'h00502223);
        chk("p2_A", A, 32'h4);
        step(0, 0, 0, 0);
        chk("p2_rel", pc_out, 32'h4);
`ifdef IFU_PERF_CNT_EN
        // Plan 6: fetch/stall counters
        step(0, 0, 0, 0);
        chk("p6_fcnt", fetch_count, 32'd3);
        chk("p6_scnt", stall_count, 32'd2);
        step(1, 0, 0, 0);
        chk("p6_fcnt_rst", fetch_count, 32'd0);
        chk("p6_scnt_rst", stall_count, 32'd0);
`endif

        // Plan 3: branch wins over stall, one bubble
        step(0, 1, 1, 32'h100);
        chk("p3_A", A, 32'h100);
        chk("p3_bubble", {31'b0, instr_valid}, 32'd0);
        step(0, 0, 0, 0);
        chk("p3_pc", pc_out, 32'h100);
        chk("p3_v", {31'b0, instr_valid}, 32'd1);

        // Plan 4: misaligned redirect faults and freezes
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h102);
        chk("p4_fault", {31'b0, fault}, 32'd1);
        chk("p4_v", {31'b0, instr_valid}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(0, i[0], i[1], 32'h200);
            chk("p4_frozen", A, 32'h4);
        end
        step(1, 0, 0, 0);
        chk("p4_clr", {31'b0, fault}, 32'd0);
        chk("p4_A", A, 32'h0);

        // Plan 5: PC wraps at top of address space
        step(0, 0, 1, 32'hFFFFFFFC);
        step(0, 0, 0, 0);
        chk("p5_pc", pc_out, 32'hFFFFFFFC);
        chk("p5_wrap", A, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 99);
            r = (k < 3);
            s = ($urandom_range(0, 99) < 30);
            b = ($urandom_range(0, 99) < 12);
            k = $urandom_range(0, 99);
            if (k < 8)       t = $urandom | 32'h1;
            else if (k < 50) t = $urandom & 32'hFFFFFFFC;
            else             t = {24'b0, 6'($urandom_range(0, 63)), 2'b00};
            step(r, s, b, t);
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Initiator side of the instruction-memory read interface. Holds the PC, drives the word address, and captures the returned instruction into an IF/ID output register with a valid flag. Supports stall, branch redirect with a single-bubble flush, and a sticky fault on misaligned targets. Sits between the instruction memory (asynchronous read, word index = address[31:2]) and decode.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
PC_INC, 4, PC increment per fetched word.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
stall  input  1  decode back-pressure; holds PC and all output registers.
branch_taken  input  1  redirect request, sampled on the rising edge.
branch_target  input  32  redirect byte address.
A  output  32  instruction-memory byte address; combinationally equal to the PC register.
RD  input  32  instruction-memory read data; combinational function of A.
pc_out  output  32  byte address of the instruction in instr_out.
instr_out  output  32  registered instruction.
instr_valid  output  1  instr_out/pc_out hold a valid instruction.
fault  output  1  sticky misaligned-redirect flag.

Behaviour:
- Reset (reset=1 at edge): pc<=RESET_PC; pc_out<=0; instr_out<=0; instr_valid<=0; fault<=0; state<=RUN. Reset overrides every other input.
- States: RUN and FAULT.
- RUN, with priority order branch_taken > stall > normal fetch.
- branch_taken=1 with branch_target[1:0]==0: pc<=branch_target; instr_valid<=0 (one bubble); instr_out/pc_out unchanged. Applies even when stall=1.
- branch_taken=1 with branch_target[1:0]!=0: fault<=1; state<=FAULT; instr_valid<=0; pc unchanged.
- stall=1, no branch: pc, pc_out, instr_out and instr_valid all hold.
- Normal fetch: instr_out<=RD; pc_out<=pc; instr_valid<=1; pc<=pc+PC_INC.
- FAULT: pc frozen; instr_valid held at 0; only reset exits this state.
- Latency: the instruction at address X appears on instr_out one edge after A==X. The first valid instruction appears on the first edge after reset deasserts.
- PC arithmetic: 32-bit modulo. 32'hFFFFFFFC + 4 wraps to 32'h00000000 with no flag.
- A is never driven with a misaligned address: the PC bits [1:0] stay 0 provided RESET_PC[1:0]==0.
- Reset asserted during a stall or branch: reset wins and the pending redirect is discarded.

Optional Feature:
IFU_PERF_CNT_EN
- Defined: adds output ports fetch_count[31:0] and stall_count[31:0].
- fetch_count increments on each normal fetch.
- stall_count increments on each RUN edge with stall=1 and branch_taken=0.
- Both counters clear on reset and wrap modulo 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Memory preloaded mem[0..2]=32'h00502223, 32'h00602423, 32'h00702623; release reset; run 3 edges -> (pc_out, instr_out) = (0x0, 0x00502223), (0x4, 0x00602423), (0x8, 0x00702623), instr_valid=1 from the first edge; A=0xC after the third edge.
2. stall=1 for 2 cycles after the first fetch -> pc_out=0x0, instr_out=0x00502223, A=0x4 held; stall released -> next edge gives pc_out=0x4.
3. branch_taken=1, branch_target=0x100, stall=1 simultaneously -> next edge: A=0x100, instr_valid=0; following edge: pc_out=0x100, instr_valid=1.
4. branch_target=0x102 -> fault=1, instr_valid=0, A frozen for 5 further edges; assert reset -> fault=0, A=RESET_PC.
5. Redirect to 0xFFFFFFFC, then one fetch -> pc_out=0xFFFFFFFC, A=0x00000000.
6. With IFU_PERF_CNT_EN defined: 3 fetches plus 2 stall cycles -> fetch_count=3, stall_count=2; reset -> both 0.
